// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debounce stage and the downstream switch block.
// Holds the FSM encoding and the switch group widths.
package sw_debounce_pkg;

    localparam int SW_W  = 16;
    localparam int CTL_W = 3;
    localparam int GRP_W = SW_W + CTL_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_PEND   = 2'd2
    } state_t;

    typedef logic [GRP_W-1:0] grp_t;

endpackage

// File: rtl/sw_debounce_if.sv
// Switch-group bus between raw board switches, the debouncer and the switch block.
// Optional commit counter present when SWDB_CHG_CNT_EN is defined.
interface sw_debounce_if;
    import sw_debounce_pkg::*;

    logic [SW_W-1:0]  sw_input;
    logic [CTL_W-1:0] sw_control;
    logic             freeze;
    logic [SW_W-1:0]  sw_val;
    logic [CTL_W-1:0] ctl_val;
    logic             sw_chg;
    logic             busy;
    state_t           dbg_state;
`ifdef SWDB_CHG_CNT_EN
    logic [7:0]       chg_cnt;
`endif

    // Strobe semantics: sw_chg is high for exactly one cycle, in the same cycle that
    // sw_val/ctl_val take their new value; no ready exists, consumers must sample it.
    modport slave (
        input  sw_input, sw_control, freeze,
        output sw_val, ctl_val, sw_chg, busy, dbg_state
`ifdef SWDB_CHG_CNT_EN
        , output chg_cnt
`endif
    );

    modport master (
        output sw_input, sw_control, freeze,
        input  sw_val, ctl_val, sw_chg, busy, dbg_state
`ifdef SWDB_CHG_CNT_EN
        , input chg_cnt
`endif
    );

endinterface

// File: rtl/sw_debounce_sync2.sv
// Parameterised-width two-flop synchroniser with asynchronous active-low reset.
module sw_debounce_sync2 #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/sw_debounce.sv
// Synchronises and debounces the 19 raw switch bits as one group, with deferred commit under freeze.
// Define SWDB_CHG_CNT_EN to add the saturating chg_cnt commit counter.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    sw_debounce_if.slave bus
);

    localparam int               CNT_W   = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    grp_t             w_s2;
    state_t           r_state, w_state_nxt;
    grp_t             r_cand,  w_cand_nxt;
    grp_t             r_out,   w_out_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             r_chg,   w_chg_nxt;
    logic             r_busy;

    sw_debounce_sync2 #(.W(GRP_W)) u_sync2 (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_d     ({bus.sw_control, bus.sw_input}),
        .o_q     (w_s2)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
            r_cand  <= '0;
            r_out   <= '0;
            r_cnt   <= '0;
            r_chg   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_out   <= w_out_nxt;
            r_cnt   <= w_cnt_nxt;
            r_chg   <= w_chg_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_out_nxt   = r_out;
        w_cnt_nxt   = r_cnt;
        w_chg_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_s2 != r_out) begin
                    w_cand_nxt  = w_s2;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_s2 != r_cand) begin
                    w_cand_nxt = w_s2;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == CNT_MAX) begin
                    // A bounce that settles back on the current outputs is dropped silently.
                    if (r_cand == r_out) begin
                        w_state_nxt = ST_IDLE;
                    end else if (bus.freeze) begin
                        w_state_nxt = ST_PEND;
                    end else begin
                        w_out_nxt   = r_cand;
                        w_chg_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_PEND: begin
                if (w_s2 != r_cand) begin
                    w_cand_nxt  = w_s2;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SETTLE;
                end else if (!bus.freeze) begin
                    w_out_nxt   = r_cand;
                    w_chg_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef SWDB_CHG_CNT_EN
    logic [7:0] r_chg_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_chg_cnt <= 8'd0;
        end else if (w_chg_nxt && (r_chg_cnt != 8'hFF)) begin
            r_chg_cnt <= r_chg_cnt + 8'd1;
        end
    end

    assign bus.chg_cnt = r_chg_cnt;
`endif

    assign bus.sw_val    = r_out[SW_W-1:0];
    assign bus.ctl_val   = r_out[GRP_W-1:SW_W];
    assign bus.sw_chg    = r_chg;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEB_CYCLES=8; commits are scored against an expected queue.
module tb_sw_debounce;
    import sw_debounce_pkg::*;

    localparam int DEB = 8;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    int   chg_seen;
    int   n_commit_exp;
    int   seen0;
    logic prev_chg;
    logic [GRP_W-1:0] exp_q[$];

    sw_debounce_if u_if();

    sw_debounce #(.DEB_CYCLES(DEB)) u_dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_commit(input logic [GRP_W-1:0] v);
        exp_q.push_back(v);
        n_commit_exp++;
    endtask

    task automatic bounce_bit0(input int n_toggles);
        for (int i = 0; i < n_toggles; i++) begin
            u_if.sw_input[0] = ~u_if.sw_input[0];
            wait_n(3);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected commit.
    always @(negedge clk) begin
        if (prev_chg) chk("chg_double", {31'd0, u_if.sw_chg}, 32'd0);
        if (u_if.sw_chg === 1'b1) begin
            chg_seen++;
            if (exp_q.size() == 0) begin
                chk("chg_unexp", {31'd0, u_if.sw_chg}, 32'd0);
            end else begin
                chk("chg_val", {13'd0, u_if.ctl_val, u_if.sw_val}, {13'd0, exp_q.pop_front()});
            end
        end
        prev_chg = (u_if.sw_chg === 1'b1);
    end

    initial begin
        n_total = 0; n_bad = 0; chg_seen = 0; n_commit_exp = 0; prev_chg = 1'b0;
        rst_n = 1'b0;
        u_if.freeze     = 1'b0;
        u_if.sw_input   = 16'($urandom_range(0, 65535));
        u_if.sw_control = 3'($urandom_range(0, 7));

        // reset with random switches
        wait_n(3);
        chk("rst_sw_val", {16'd0, u_if.sw_val}, 32'd0);
        chk("rst_ctl_val", {29'd0, u_if.ctl_val}, 32'd0);
        chk("rst_chg", {31'd0, u_if.sw_chg}, 32'd0);
        chk("rst_busy", {31'd0, u_if.busy}, 32'd0);
        chk("rst_state", {30'd0, u_if.dbg_state}, {30'd0, ST_IDLE});
        u_if.sw_input   = 16'h0000;
        u_if.sw_control = 3'b000;
        rst_n = 1'b1;
        wait_n(4);
        chk("idle_busy", {31'd0, u_if.busy}, 32'd0);

        // clean step: commit exactly DEB+3 edges after the change
        expect_commit({3'b000, 16'h00A5});
        u_if.sw_input = 16'h00A5;
        wait_n(DEB + 2);
        chk("step_early_val", {16'd0, u_if.sw_val}, 32'd0);
        chk("step_early_chg", {31'd0, u_if.sw_chg}, 32'd0);
        wait_n(1);
        chk("step_val", {16'd0, u_if.sw_val}, 32'h00A5);
        chk("step_chg", {31'd0, u_if.sw_chg}, 32'd1);
        wait_n(1);
        chk("step_chg_low", {31'd0, u_if.sw_chg}, 32'd0);
        chk("step_busy", {31'd0, u_if.busy}, 32'd0);

        // bounce ending on a new value: one commit, no intermediate value
        expect_commit({3'b000, 16'h00A4});
        u_if.sw_input = 16'h00A4;
        wait_n(DEB + 6);
        seen0 = chg_seen;
        bounce_bit0(8);
        expect_commit({3'b000, 16'h00A5});
        u_if.sw_input[0] = 1'b1;
        wait_n(DEB + 6);
        chk("bounce_new_cnt", chg_seen, seen0 + 1);
        chk("bounce_new_val", {16'd0, u_if.sw_val}, 32'h00A5);

        // bounce returning to the old value: no commit
        seen0 = chg_seen;
        bounce_bit0(8);
        wait_n(DEB + 6);
        chk("bounce_old_cnt", chg_seen, seen0);
        chk("bounce_old_busy", {31'd0, u_if.busy}, 32'd0);

        // freeze held across the settle: deferred until release
        u_if.freeze     = 1'b1;
        u_if.sw_control = 3'b101;
        wait_n(20);
        chk("frz_busy", {31'd0, u_if.busy}, 32'd1);
        chk("frz_ctl", {29'd0, u_if.ctl_val}, 32'd0);
        chk("frz_state", {30'd0, u_if.dbg_state}, {30'd0, ST_PEND});
        expect_commit({3'b101, 16'h00A5});
        u_if.freeze = 1'b0;
        wait_n(1);
        chk("unfrz_chg", {31'd0, u_if.sw_chg}, 32'd1);
        chk("unfrz_ctl", {29'd0, u_if.ctl_val}, 32'd5);
        wait_n(2);
        chk("unfrz_busy", {31'd0, u_if.busy}, 32'd0);

        // freeze rising in the commit cycle wins
        u_if.sw_control = 3'b011;
        wait_n(DEB + 2);
        u_if.freeze = 1'b1;
        wait_n(1);
        chk("frz_edge_chg", {31'd0, u_if.sw_chg}, 32'd0);
        chk("frz_edge_busy", {31'd0, u_if.busy}, 32'd1);
        chk("frz_edge_ctl", {29'd0, u_if.ctl_val}, 32'd5);
        wait_n(3);
        expect_commit({3'b011, 16'h00A5});
        u_if.freeze = 1'b0;
        wait_n(1);
        chk("frz_edge_commit", {29'd0, u_if.ctl_val}, 32'd3);

        // reset while settling at cnt=4, then re-debounce from scratch
        wait_n(3);
        u_if.sw_input = 16'h1234;
        wait_n(7);
        chk("mid_busy_pre", {31'd0, u_if.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sw", {16'd0, u_if.sw_val}, 32'd0);
        chk("mid_rst_ctl", {29'd0, u_if.ctl_val}, 32'd0);
        chk("mid_rst_busy", {31'd0, u_if.busy}, 32'd0);
        chk("mid_rst_state", {30'd0, u_if.dbg_state}, {30'd0, ST_IDLE});
        wait_n(2);
        expect_commit({3'b011, 16'h1234});
        rst_n = 1'b1;
        wait_n(DEB + 2);
        chk("mid_early_val", {16'd0, u_if.sw_val}, 32'd0);
        wait_n(1);
        chk("mid_val", {16'd0, u_if.sw_val}, 32'h1234);
        chk("mid_chg", {31'd0, u_if.sw_chg}, 32'd1);

`ifdef SWDB_CHG_CNT_EN
        chk("cnt_after_rst", {24'd0, u_if.chg_cnt}, 32'd1);
        for (int i = 0; i < 300; i++) begin
            wait_n(2);
            expect_commit({3'b011, 16'(i + 1) ^ 16'h8000});
            u_if.sw_input = 16'(i + 1) ^ 16'h8000;
            wait_n(DEB + 4);
        end
        chk("cnt_sat", {24'd0, u_if.chg_cnt}, 32'h0FF);
`endif

        wait_n(5);
        chk("q_empty", exp_q.size(), 32'd0);
        chk("commit_total", chg_seen, n_commit_exp);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
